// File: rtl/intersection_model.sv
// Cycle-level model of one 4-way intersection: wait slots, 2x2 centre grid, crash/bad-code flags.
// Optional exit statistics counter enabled by defining INTERSECTION_STATS_EN.
module intersection_model #(
  parameter int STEP_CYCLES = 4,
  parameter int STAT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  lightN,
  input  logic [2:0]  lightS,
  input  logic [2:0]  lightE,
  input  logic [2:0]  lightW,
  input  logic [3:0]  arrive_valid,
  input  logic [7:0]  arrive_intent,
  output logic [3:0]  arrive_ready,
  output logic [7:0]  sensor_light,
  output logic [3:0]  exit_valid,
  output logic        crash,
  output logic        bad_code
`ifdef INTERSECTION_STATS_EN
  ,
  output logic [STAT_W-1:0] exit_count
`endif
);

  localparam int CNT_W = $clog2(STEP_CYCLES);

  // Cells 0..3 are the centre grid, 4..7 the approach wait slots.
  logic [7:0]       occ;
  logic [1:0]       org [8];
  logic [1:0]       itn [8];
  logic [1:0]       hop [8];
  logic [CNT_W-1:0] cnt;

  logic [7:0]       occ_n;
  logic [1:0]       org_n [8];
  logic [1:0]       itn_n [8];
  logic [1:0]       hop_n [8];
  logic [3:0]       exit_n;
  logic [3:0]       ready_n;
  logic             crash_n;
  logic             bad_n;

  logic [2:0]       light [4];
  logic             tick;
  logic [7:0]       mv;
  logic [7:0]       lv;
  logic [1:0]       tgt [8];
  logic [3:0]       hit;
  logic [3:0]       ex_hits;
  logic             dup;
  logic             bad_any;
  logic             apply;
  logic [2:0]       s;
  logic [1:0]       ai;

  assign light[0] = lightN;
  assign light[1] = lightS;
  assign light[2] = lightE;
  assign light[3] = lightW;
  assign tick = (cnt == CNT_W'(STEP_CYCLES - 1));
  assign sensor_light = occ;

  // Every path of an origin is a prefix of one cell sequence; only length and exit differ by intent.
  function automatic logic [1:0] path_cell(input logic [1:0] o, input logic [1:0] h);
    logic [1:0] c;
    case (o)
      2'd0:    c = (h == 2'd0) ? 2'd3 : (h == 2'd1) ? 2'd1 : 2'd0;
      2'd1:    c = (h == 2'd0) ? 2'd0 : (h == 2'd1) ? 2'd2 : 2'd3;
      2'd2:    c = (h == 2'd0) ? 2'd2 : (h == 2'd1) ? 2'd3 : 2'd1;
      default: c = (h == 2'd0) ? 2'd1 : (h == 2'd1) ? 2'd0 : 2'd2;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] path_len(input logic [1:0] i);
    return (i == 2'b01) ? 2'd3 : (i == 2'b10) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] exit_head(input logic [1:0] o, input logic [1:0] i);
    logic [1:0] e;
    case (o)
      2'd0:    e = (i == 2'b10) ? 2'd2 : (i == 2'b01) ? 2'd3 : 2'd0;
      2'd1:    e = (i == 2'b10) ? 2'd3 : (i == 2'b01) ? 2'd2 : 2'd1;
      2'd2:    e = (i == 2'b10) ? 2'd1 : (i == 2'b01) ? 2'd0 : 2'd2;
      default: e = (i == 2'b10) ? 2'd0 : (i == 2'b01) ? 2'd1 : 2'd3;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] slot_of(input logic [1:0] d);
    logic [2:0] r;
    case (d)
      2'd0:    r = 3'd6;
      2'd1:    r = 3'd4;
      2'd2:    r = 3'd5;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  function automatic logic permit(input logic [2:0] code, input logic [1:0] i);
    logic p;
    case (code)
      3'b001:  p = (i == 2'b00);
      3'b010:  p = (i == 2'b01);
      3'b011:  p = (i == 2'b10);
      3'b100:  p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  always_comb begin
    mv = '0;
    lv = '0;
    hit = '0;
    ex_hits = '0;
    dup = 1'b0;
    bad_any = 1'b0;
    s = '0;
    ai = '0;
    for (int c = 0; c < 8; c++) tgt[c] = '0;

    // Movers are judged purely on tick-start occupancy, so vacating cells never free a target.
    for (int c = 0; c < 4; c++) begin
      tgt[c] = path_cell(org[c], hop[c] + 2'd1);
      if (occ[c] && (hop[c] == path_len(itn[c]) - 2'd1)) begin
        lv[c] = 1'b1;
        ex_hits[exit_head(org[c], itn[c])] = 1'b1;
      end else if (occ[c] && !occ[tgt[c]]) begin
        mv[c] = 1'b1;
      end
    end
    for (int d = 0; d < 4; d++) begin
      if (light[d] > 3'b100) bad_any = 1'b1;
      s = slot_of(2'(d));
      tgt[s] = path_cell(2'(d), 2'd0);
      if (occ[s] && permit(light[d], itn[s]) && !occ[tgt[s]]) mv[s] = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      if (mv[c]) begin
        if (hit[tgt[c]]) dup = 1'b1;
        hit[tgt[c]] = 1'b1;
      end
    end
    apply = tick && !crash && !dup;

    occ_n = occ;
    org_n = org;
    itn_n = itn;
    hop_n = hop;
    if (apply) begin
      for (int c = 0; c < 8; c++) begin
        if (mv[c] || lv[c]) occ_n[c] = 1'b0;
      end
      for (int c = 0; c < 8; c++) begin
        if (mv[c]) begin
          occ_n[tgt[c]] = 1'b1;
          org_n[tgt[c]] = org[c];
          itn_n[tgt[c]] = itn[c];
          hop_n[tgt[c]] = (c >= 4) ? 2'd0 : hop[c] + 2'd1;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      s = slot_of(2'(d));
      ai = arrive_intent[2*d +: 2];
      if (arrive_valid[d] && arrive_ready[d]) begin
        occ_n[s] = 1'b1;
        org_n[s] = 2'(d);
        itn_n[s] = (ai == 2'b11) ? 2'b00 : ai;
        hop_n[s] = 2'd0;
      end
    end

    exit_n  = apply ? ex_hits : 4'h0;
    crash_n = crash | (tick && dup);
    bad_n   = bad_code | (tick && bad_any);
    ready_n = ~{occ_n[7], occ_n[5], occ_n[4], occ_n[6]} & {4{~crash_n}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      for (int c = 0; c < 8; c++) begin
        org[c] <= '0;
        itn[c] <= '0;
        hop[c] <= '0;
      end
      cnt          <= '0;
      exit_valid   <= '0;
      crash        <= 1'b0;
      bad_code     <= 1'b0;
      arrive_ready <= 4'hF;
    end else begin
      occ          <= occ_n;
      org          <= org_n;
      itn          <= itn_n;
      hop          <= hop_n;
      cnt          <= tick ? '0 : cnt + CNT_W'(1);
      exit_valid   <= exit_n;
      crash        <= crash_n;
      bad_code     <= bad_n;
      arrive_ready <= ready_n;
    end
  end

`ifdef INTERSECTION_STATS_EN
  logic [STAT_W:0] count_sum;
  assign count_sum = {1'b0, exit_count} + (STAT_W+1)'($countones(exit_valid));

  always_ff @(posedge clk) begin
    if (rst) exit_count <= '0;
    else     exit_count <= count_sum[STAT_W] ? {STAT_W{1'b1}} : count_sum[STAT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_intersection_model.sv
// Directed bench for intersection_model: light-decode vector table plus multi-tick traversal,
// hold, crash, blocking and reset sequences (STEP_CYCLES = 4).
module tb_intersection_model;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lightN, lightS, lightE, lightW;
  logic [3:0] arrive_valid;
  logic [7:0] arrive_intent;
  logic [3:0] arrive_ready;
  logic [7:0] sensor_light;
  logic [3:0] exit_valid;
  logic       crash;
  logic       bad_code;
`ifdef INTERSECTION_STATS_EN
  logic [15:0] exit_count;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  intersection_model #(.STEP_CYCLES(4), .STAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .lightN(lightN), .lightS(lightS), .lightE(lightE), .lightW(lightW),
    .arrive_valid(arrive_valid), .arrive_intent(arrive_intent),
    .arrive_ready(arrive_ready), .sensor_light(sensor_light),
    .exit_valid(exit_valid), .crash(crash), .bad_code(bad_code)
`ifdef INTERSECTION_STATS_EN
    , .exit_count(exit_count)
`endif
  );

  typedef struct {
    int         appr;
    logic [1:0] intent;
    logic [2:0] code;
    logic [7:0] exp_sensor;
    logic       exp_bad;
  } vec_t;

  vec_t vt[13];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Ticks land on every 4th edge after reset release.
  task automatic goto_tick();
    do step(); while (cyc % 4 != 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_light(input int d, input logic [2:0] code);
    case (d)
      0:       lightN = code;
      1:       lightS = code;
      2:       lightE = code;
      default: lightW = code;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lightN = 3'b000; lightS = 3'b000; lightE = 3'b000; lightW = 3'b000;
    arrive_valid = 4'h0;
    arrive_intent = 8'h00;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic arrive(input int d, input logic [1:0] intent);
    arrive_valid[d] = 1'b1;
    arrive_intent[2*d +: 2] = intent;
    step();
    arrive_valid = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0, 2'b00, 3'b100, 8'h08, 1'b0};
    vt[1]  = '{0, 2'b00, 3'b000, 8'h40, 1'b0};
    vt[2]  = '{0, 2'b00, 3'b001, 8'h08, 1'b0};
    vt[3]  = '{0, 2'b01, 3'b001, 8'h40, 1'b0};
    vt[4]  = '{1, 2'b01, 3'b010, 8'h01, 1'b0};
    vt[5]  = '{1, 2'b10, 3'b010, 8'h10, 1'b0};
    vt[6]  = '{2, 2'b10, 3'b011, 8'h04, 1'b0};
    vt[7]  = '{2, 2'b00, 3'b011, 8'h20, 1'b0};
    vt[8]  = '{3, 2'b11, 3'b001, 8'h02, 1'b0};
    vt[9]  = '{3, 2'b00, 3'b101, 8'h80, 1'b1};
    vt[10] = '{1, 2'b00, 3'b110, 8'h10, 1'b1};
    vt[11] = '{2, 2'b01, 3'b111, 8'h20, 1'b1};
    vt[12] = '{3, 2'b10, 3'b100, 8'h02, 1'b0};

    // Reset state
    do_reset();
    chk("reset_sensor", sensor_light, 8'h00);
    chk("reset_ready", arrive_ready, 4'hF);
    chk("reset_exit", exit_valid, 4'h0);
    chk("reset_crash", crash, 1'b0);
    chk("reset_bad", bad_code, 1'b0);

    // N-bound forward traversal
    lightN = 3'b100;
    arrive(0, 2'b00);
    chk("t1_wait_sensor", sensor_light, 8'h40);
    chk("t1_wait_ready", arrive_ready, 4'hE);
    goto_tick();
    chk("t1_tick1_sensor", sensor_light, 8'h08);
    chk("t1_tick1_ready", arrive_ready, 4'hF);
    goto_tick();
    chk("t1_tick2_sensor", sensor_light, 8'h02);
    step(); step(); step();
    chk("t1_pre_exit", exit_valid, 4'h0);
    step();
    chk("t1_tick3_sensor", sensor_light, 8'h00);
    chk("t1_tick3_exit", exit_valid, 4'b0001);
    step();
    chk("t1_exit_one_cycle", exit_valid, 4'h0);

    // Light decode table
    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_light(vt[i].appr, vt[i].code);
      arrive(vt[i].appr, vt[i].intent);
      goto_tick();
      chk($sformatf("vec%0d_sensor", i), sensor_light, vt[i].exp_sensor);
      chk($sformatf("vec%0d_bad", i), bad_code, vt[i].exp_bad);
    end

    // Stop hold for 20 ticks, then forward-only release
    do_reset();
    arrive(0, 2'b00);
    for (int t = 0; t < 20; t++) begin
      goto_tick();
      chk("t2_hold_sensor", sensor_light, 8'h40);
      chk("t2_hold_ready", arrive_ready[0], 1'b0);
      chk("t2_hold_exit", exit_valid, 4'h0);
    end
    lightN = 3'b001;
    goto_tick();
    chk("t2_release_sensor", sensor_light, 8'h08);

    // Intent mismatch then right turn
    do_reset();
    lightE = 3'b010;
    arrive(2, 2'b10);
    goto_tick();
    chk("t3_mismatch_sensor", sensor_light, 8'h20);
    lightE = 3'b011;
    goto_tick();
    chk("t3_enter_sensor", sensor_light, 8'h04);
    goto_tick();
    chk("t3_exit", exit_valid, 4'b0010);
    chk("t3_empty", sensor_light, 8'h00);
    step();
    chk("t3_exit_clear", exit_valid, 4'h0);

    // Crash: two movers into cell 3
    do_reset();
    lightE = 3'b100;
    lightN = 3'b100;
    arrive(2, 2'b00);
    goto_tick();
    chk("t4_e_in_2", sensor_light, 8'h04);
    arrive(0, 2'b00);
    chk("t4_n_wait", sensor_light, 8'h44);
    goto_tick();
    chk("t4_crash", crash, 1'b1);
    chk("t4_frozen_sensor", sensor_light, 8'h44);
    chk("t4_ready_low", arrive_ready, 4'h0);
    arrive_valid = 4'hF;
    for (int t = 0; t < 2; t++) begin
      goto_tick();
      chk("t4_still_frozen", sensor_light, 8'h44);
      chk("t4_no_exit", exit_valid, 4'h0);
      chk("t4_crash_sticky", crash, 1'b1);
      chk("t4_ready_held", arrive_ready, 4'h0);
    end
    arrive_valid = 4'h0;
    do_reset();
    chk("t4_rst_crash", crash, 1'b0);
    chk("t4_rst_ready", arrive_ready, 4'hF);
    chk("t4_rst_sensor", sensor_light, 8'h00);

    // Blocked by a cell being vacated on the same tick
    do_reset();
    lightE = 3'b100;
    lightW = 3'b100;
    arrive(2, 2'b01);
    goto_tick();
    chk("t5_e_in_2", sensor_light, 8'h04);
    arrive(3, 2'b00);
    goto_tick();
    chk("t5_e3_w1", sensor_light, 8'h0A);
    goto_tick();
    chk("t5_e_holds", sensor_light, 8'h09);
    chk("t5_no_crash", crash, 1'b0);
    goto_tick();
    chk("t5_e_in_1", sensor_light, 8'h02);
    chk("t5_w_exit", exit_valid, 4'b1000);
    chk("t5_no_crash2", crash, 1'b0);
    goto_tick();
    chk("t5_e_exit", exit_valid, 4'b0001);
    chk("t5_empty", sensor_light, 8'h00);

    // Bad code hold, then reset mid-traversal on the would-be exit tick
    do_reset();
    lightS = 3'b111;
    arrive(1, 2'b00);
    goto_tick();
    chk("t6_hold_sensor", sensor_light, 8'h10);
    chk("t6_bad", bad_code, 1'b1);
    chk("t6_no_crash", crash, 1'b0);
    lightS = 3'b100;
    goto_tick();
    chk("t6_enter", sensor_light, 8'h01);
    chk("t6_bad_sticky", bad_code, 1'b1);
    goto_tick();
    chk("t6_cell2", sensor_light, 8'h04);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("t6_rst_sensor", sensor_light, 8'h00);
    chk("t6_rst_bad", bad_code, 1'b0);
    chk("t6_rst_crash", crash, 1'b0);
    chk("t6_rst_ready", arrive_ready, 4'hF);
    chk("t6_rst_exit", exit_valid, 4'h0);
    rst = 1'b0;
    cyc = 0;
    step();
    chk("t6_post_exit", exit_valid, 4'h0);
    chk("t6_post_sensor", sensor_light, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
